// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store memory stage.
//   DATA_W / LANE_W / LANES : memory word geometry (256-bit word, eight 32-bit lanes)
//   ADDR_W                  : request address width (word index)
//   MEM_DEPTH               : number of words backed by the data memory
//   state_t                 : sequencer states
//   req_t                   : latched copy of one accepted request
package lsu_pkg;

  localparam int DATA_W    = 256;
  localparam int LANE_W    = 32;
  localparam int LANES     = DATA_W / LANE_W;
  localparam int ADDR_W    = 32;
  localparam int MEM_DEPTH = 1024;
  localparam int TAG_W     = 5;
  localparam int MEM_A_W   = 256;

  localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(MEM_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    ACCESS,
    MERGE,
    WRITE,
    RESP
  } state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [LANES-1:0]  mask;
    logic [TAG_W-1:0]  tag;
  } req_t;

endpackage

// File: rtl/lane_merge.sv
// Per-lane select between new and old data under a lane mask.
//   mask     : lane i takes new_data when mask[i] = 1, else old_data
//   new_data : incoming lanes
//   old_data : existing lanes
//   merged   : combined word
module lane_merge
  import lsu_pkg::*;
(
  input  logic [LANES-1:0]  mask,
  input  logic [DATA_W-1:0] new_data,
  input  logic [DATA_W-1:0] old_data,
  output logic [DATA_W-1:0] merged
);

  // NOTE: every combinational output gets a default before any conditional
  // assignment, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    merged = old_data;
    for (int i = 0; i < LANES; i++) begin
      if (mask[i]) merged[i*LANE_W +: LANE_W] = new_data[i*LANE_W +: LANE_W];
    end
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// Load/store sequencer between vector execute and the 1024 x 256-bit data
// memory. One request in flight; partial stores are read-modify-write.
//   clk, rst            : clock, synchronous active-high reset
//   req_*               : request handshake (valid/ready) and payload
//   rsp_*               : response handshake (valid/ready), load data, tag, error
//   mem_we/mem_a/mem_wd : memory write enable, word address, write data
//   mem_rd              : memory read data (combinational from mem_a)
module lsu_mem_stage
  import lsu_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [ADDR_W-1:0]  req_addr,
  input  logic [DATA_W-1:0]  req_wdata,
  input  logic [LANES-1:0]   req_mask,
  input  logic [TAG_W-1:0]   req_tag,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DATA_W-1:0]  rsp_rdata,
  output logic [TAG_W-1:0]   rsp_tag,
  output logic               rsp_err,
  output logic               mem_we,
  output logic [MEM_A_W-1:0] mem_a,
  output logic [DATA_W-1:0]  mem_wd,
  input  logic [DATA_W-1:0]  mem_rd
);

  state_t            state, state_nxt;
  req_t              req_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic [DATA_W-1:0] merged;
  logic              accept;
  logic              addr_oor;

  // Reset takes priority in the state register, so accept need not see rst.
  assign accept   = (state == IDLE) & req_valid;
  assign addr_oor = req_addr >= ADDR_LIMIT;

  assign req_ready = (state == IDLE) & ~rst;
  assign rsp_valid = (state == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_tag   = req_q.tag;
  assign rsp_err   = err_q;

  lane_merge u_lane_merge (
    .mask     (req_q.mask),
    .new_data (req_q.wdata),
    .old_data (mem_rd),
    .merged   (merged)
  );

  always_comb begin
    state_nxt = state;
    mem_we    = 1'b0;
    mem_a     = '0;
    mem_wd    = '0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (addr_oor)            state_nxt = RESP;
          else if (!req_we)        state_nxt = ACCESS;
          else if (&req_mask)      state_nxt = WRITE;
          else if (req_mask == '0) state_nxt = RESP;
          else                     state_nxt = MERGE;
        end
      end
      ACCESS: begin
        mem_a     = MEM_A_W'(req_q.addr);
        state_nxt = RESP;
      end
      MERGE: begin
        mem_a     = MEM_A_W'(req_q.addr);
        state_nxt = WRITE;
      end
      WRITE: begin
        mem_a     = MEM_A_W'(req_q.addr);
        mem_wd    = req_q.wdata;
        // A reset landing on the write cycle must leave memory untouched.
        mem_we    = ~rst;
        state_nxt = RESP;
      end
      RESP: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      req_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      unique case (state)
        IDLE: begin
          if (accept) begin
            req_q   <= '{we: req_we, addr: req_addr, wdata: req_wdata,
                         mask: req_mask, tag: req_tag};
            // Cleared here so stores and errors answer with zero data.
            rdata_q <= '0;
            err_q   <= addr_oor;
          end
        end
        ACCESS:  rdata_q <= req_q.we ? '0 : mem_rd;
        MERGE:   req_q.wdata <= merged;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/lsu_mem_stage.md
# lsu_mem_stage

Load/store sequencer between the vector execute stage and the 1024 × 256-bit data memory. Accepts one memory request at a time over a valid/ready handshake and drives the memory's word address, write enable and write data. Performs lane-masked stores as read-modify-write, since the memory has no byte enables. Returns load data or store completion over a second valid/ready handshake to writeback.

## Interface
- `DATA_W`, 256: memory word width.
- `LANE_W`, 32: lane width.
- `LANES`, 8: lanes per word (`DATA_W/LANE_W`).
- `ADDR_W`, 32: request address width (word index, not byte address).
- `MEM_DEPTH`, 1024: valid word indices are 0..`MEM_DEPTH`-1.
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept a request.
- `req_we` in 1: 1 = store, 0 = load.
- `req_addr` in `ADDR_W`: word index.
- `req_wdata` in `DATA_W`: store data. Lane i is bits [32i+31:32i].
- `req_mask` in `LANES`: store lane enables; ignored for loads.
- `req_tag` in 5: destination register tag, returned unchanged.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_rdata` out `DATA_W`: load data; 0 for stores and errors.
- `rsp_tag` out 5: tag of the completed request.
- `rsp_err` out 1: address was out of range.
- `mem_we` out 1: memory write enable, sampled by memory at `clk` edge.
- `mem_a` out 256: memory word address, zero-extended from `ADDR_W`.
- `mem_wd` out `DATA_W`: memory write data.
- `mem_rd` in `DATA_W`: memory read data, combinational from `mem_a`.

## Operation
- States:
  - IDLE: `req_ready` = 1. A handshake (`req_valid` & `req_ready`) latches `req_we`, `req_addr`, `req_wdata`, `req_mask` and `req_tag` into `*_q` registers.
  - ACCESS (load): `mem_a` = `addr_q`. `mem_rd` is captured into `rdata_q`. → RESP.
  - MERGE (partial store): `mem_a` = `addr_q`. `wdata_q` ← per lane, `mask_q[i]` ? `wdata_q` lane : `mem_rd` lane. → WRITE.
  - WRITE: `mem_a` = `addr_q`, `mem_wd` = `wdata_q`, `mem_we` = 1. → RESP.
  - RESP: `rsp_valid` = 1; `rsp_*` are driven from the `*_q` registers and held stable. When `rsp_ready` = 1, → IDLE.
- Dispatch from IDLE on handshake, in priority order:
  1. `req_addr` ≥ `MEM_DEPTH` → RESP with `rsp_err` = 1. No memory write for either loads or stores.
  2. Load → ACCESS.
  3. Store with `req_mask` = all ones → WRITE, with `wdata_q` = `req_wdata`.
  4. Store with `req_mask` = 0 → RESP. No write; `rsp_err` = 0.
  5. Other stores → MERGE.
- `mem_we` = (state == WRITE) & ~`rst`. A reset cycle never writes memory.
- `mem_a` = 0 in IDLE. `mem_wd` = 0 outside WRITE.
- `req_ready` is 0 in every state except IDLE. There is no request/response overlap: one request in flight.
- No combinational path from `req_*` to `mem_*`, or from `rsp_ready` to `req_ready`.

## Timing
- Reset: state = IDLE; `req_ready` = 1 the cycle after `rst` deasserts, 0 while `rst` is high. `rsp_valid`, `rsp_err`, `mem_we` = 0. `rsp_rdata`, `rsp_tag`, `mem_a`, `mem_wd` = 0. All `*_q` registers = 0.
- Latency is counted from the accept edge T to `rsp_valid` high:
  - Load: T+2.
  - Full-mask store: T+2, with the memory written at the T+2 edge.
  - Partial store: T+3.
  - Error or zero-mask store: T+1.
- Throughput with `rsp_ready` tied high: one load per 3 cycles, one partial store per 4 cycles.
- Back-pressure: RESP holds indefinitely. `rsp_*` must not change while `rsp_valid` & ~`rsp_ready`.
- `rst` mid-operation: the request is dropped and no response is produced. If `rst` is high during WRITE, memory is unchanged.

## Structure
- Package `lsu_pkg`:
  - state enum (IDLE, ACCESS, MERGE, WRITE, RESP);
  - `LANES`, `LANE_W`, `MEM_DEPTH` constants;
  - request struct {we, addr, wdata, mask, tag}.
- Sub-module `lane_merge`: combinational per-lane select of new data vs. old data under the mask. It is reusable by future masked-load logic.

## Test plan
- Memory word 100 preloaded 0x00000009_0000000A_…_00000010. Load addr 100, tag 5 → `rsp_valid` at T+2, `rsp_rdata` equals the preload, `rsp_tag` = 5, `rsp_err` = 0.
- Store addr 104, data 0x…_AAAAAAAA in all lanes, mask 0x0F → at T+3 word 104 has lanes 0–3 = 0xAAAAAAAA and lanes 4–7 unchanged (0x00000001…0x00000004). `mem_we` is high for exactly 1 cycle.
- Full-mask store to addr 7, followed by a load of addr 7 → load returns the stored word. `req_ready` is low throughout the store.
- Load addr 1024, and store addr 0xFFFFFFFF → `rsp_err` = 1 at T+1, `rsp_rdata` = 0, `mem_we` never asserted.
- Hold `rsp_ready` = 0 for 10 cycles after a load → `rsp_*` stable, `req_ready` = 0. Release → next request accepted the following cycle.
- Assert `rst` during WRITE of a store to addr 50 → word 50 unchanged, no response, and all outputs at their reset values next cycle.
